// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run-control, event counters and post-mortem PC trace beside the multicycle CPU.
// Optional PC trace buffer is built only when CPU_MON_TRACE_EN is defined.
module cpu_run_monitor #(
    parameter int XLEN           = 64,
    parameter int STATE_W        = 5,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int HANG_CYCLES    = 64,
    parameter int TRACE_DEPTH    = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [XLEN-1:0]                pc_i,
    input  logic [STATE_W-1:0]             estado_i,
    input  logic                           ir_write_i,
    input  logic                           reg_write_i,
    input  logic                           wr_data_mem_i,
    input  logic                           exc_i,
    output logic [CNT_W-1:0]               cycle_count_o,
    output logic [CNT_W-1:0]               instr_count_o,
    output logic [CNT_W-1:0]               reg_write_count_o,
    output logic [CNT_W-1:0]               mem_write_count_o,
    output logic                           stop_o,
    output logic [1:0]                     stop_cause_o,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx_i,
    output logic [XLEN-1:0]                trace_rd_pc_o,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count_o
);
    localparam int IDX_W  = $clog2(TRACE_DEPTH);
    localparam int HANG_W = $clog2(HANG_CYCLES + 1);
    // A budget wider than the cycle counter can never be reached, so timeout is disabled then.
    localparam bit TIMEOUT_REACHABLE = ($clog2(TIMEOUT_CYCLES + 1) <= CNT_W);

    typedef enum logic {RUN = 1'b0, STOPPED = 1'b1} runState_t;

    runState_t          state;
    logic [CNT_W-1:0]   cycleCount, instrCount, regWriteCount, memWriteCount;
    logic [CNT_W-1:0]   cycleNext, instrNext, regWriteNext, memWriteNext;
    logic [XLEN-1:0]    pcQ;
    logic [STATE_W-1:0] estadoQ;
    logic               sampleValid;
    logic [HANG_W-1:0]  hangCnt, hangNext;
    logic [1:0]         stopCause;
    logic               hangHit, timeoutHit;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        cycleNext    = satInc(cycleCount, 1'b1);
        instrNext    = satInc(instrCount, ir_write_i);
        regWriteNext = satInc(regWriteCount, reg_write_i);
        memWriteNext = satInc(memWriteCount, wr_data_mem_i);
        hangNext     = (sampleValid && (pc_i == pcQ) && (estado_i == estadoQ))
                       ? hangCnt + HANG_W'(1) : '0;
        hangHit      = (hangNext == HANG_W'(HANG_CYCLES));
        timeoutHit   = TIMEOUT_REACHABLE && (cycleNext == CNT_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            cycleCount    <= '0;
            instrCount    <= '0;
            regWriteCount <= '0;
            memWriteCount <= '0;
            pcQ           <= '0;
            estadoQ       <= '0;
            sampleValid   <= 1'b0;
            hangCnt       <= '0;
            stopCause     <= 2'd0;
        end else if (state == RUN) begin
            cycleCount    <= cycleNext;
            instrCount    <= instrNext;
            regWriteCount <= regWriteNext;
            memWriteCount <= memWriteNext;
            pcQ           <= pc_i;
            estadoQ       <= estado_i;
            sampleValid   <= 1'b1;
            hangCnt       <= hangNext;
            // The cause is written once on the way into STOPPED; STOPPED freezes it.
            if (exc_i) begin
                state     <= STOPPED;
                stopCause <= 2'd3;
            end else if (hangHit) begin
                state     <= STOPPED;
                stopCause <= 2'd2;
            end else if (timeoutHit) begin
                state     <= STOPPED;
                stopCause <= 2'd1;
            end
        end
    end

    assign cycle_count_o     = cycleCount;
    assign instr_count_o     = instrCount;
    assign reg_write_count_o = regWriteCount;
    assign mem_write_count_o = memWriteCount;
    assign stop_o            = (state == STOPPED);
    assign stop_cause_o      = stopCause;

`ifdef CPU_MON_TRACE_EN
    logic [XLEN-1:0]  traceMem [TRACE_DEPTH];
    logic [IDX_W-1:0] wrPtr, rdAddr;
    logic [IDX_W:0]   traceCount;
    logic [XLEN-1:0]  rdPcQ;

    // wrPtr points at the next free slot, so the newest entry sits one below it.
    assign rdAddr = wrPtr - IDX_W'(1) - trace_rd_idx_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) traceMem[i] <= '0;
            wrPtr      <= '0;
            traceCount <= '0;
            rdPcQ      <= '0;
        end else begin
            rdPcQ <= ({1'b0, trace_rd_idx_i} < traceCount) ? traceMem[rdAddr] : '0;
            if ((state == RUN) && ir_write_i) begin
                traceMem[wrPtr] <= pc_i;
                wrPtr           <= wrPtr + IDX_W'(1);
                if (traceCount != (IDX_W + 1)'(TRACE_DEPTH))
                    traceCount <= traceCount + (IDX_W + 1)'(1);
            end
        end
    end

    assign trace_rd_pc_o = rdPcQ;
    assign trace_count_o = traceCount;
`else
    logic unusedTraceIdx;
    assign unusedTraceIdx = ^trace_rd_idx_i;
    assign trace_rd_pc_o  = '0;
    assign trace_count_o  = '0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: vector table, directed corner sequences and
// randomized traffic against a behavioural model; trace expectations follow CPU_MON_TRACE_EN.
module tb_cpu_run_monitor;
    localparam int TIMEOUT = 100;
    localparam int HANG    = 8;
    localparam int DEPTH   = 16;
    localparam int A_MAX   = 255;
`ifdef CPU_MON_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic        clock, reset;
    logic [31:0] pc;
    logic [4:0]  estado;
    logic        irW, regW, memW, exc;
    logic [3:0]  rdIdx;

    logic [7:0]  aCycle, aInstr, aRw, aMw;
    logic        aStop;
    logic [1:0]  aCause;
    logic [31:0] aTracePc;
    logic [4:0]  aTraceCnt;

    logic [3:0]  bCycle, bInstr, bRw, bMw;
    logic        bStop;
    logic [1:0]  bCause;
    logic [31:0] bTracePc;
    logic [4:0]  bTraceCnt;

    cpu_run_monitor #(.XLEN(32), .STATE_W(5), .CNT_W(8), .TIMEOUT_CYCLES(TIMEOUT),
                      .HANG_CYCLES(HANG), .TRACE_DEPTH(DEPTH)) dutA (
        .clock(clock), .reset(reset), .pc_i(pc), .estado_i(estado),
        .ir_write_i(irW), .reg_write_i(regW), .wr_data_mem_i(memW), .exc_i(exc),
        .cycle_count_o(aCycle), .instr_count_o(aInstr), .reg_write_count_o(aRw),
        .mem_write_count_o(aMw), .stop_o(aStop), .stop_cause_o(aCause),
        .trace_rd_idx_i(rdIdx), .trace_rd_pc_o(aTracePc), .trace_count_o(aTraceCnt));

    cpu_run_monitor #(.XLEN(32), .STATE_W(5), .CNT_W(4), .TIMEOUT_CYCLES(1000),
                      .HANG_CYCLES(64), .TRACE_DEPTH(DEPTH)) dutB (
        .clock(clock), .reset(reset), .pc_i(pc), .estado_i(estado),
        .ir_write_i(irW), .reg_write_i(regW), .wr_data_mem_i(memW), .exc_i(exc),
        .cycle_count_o(bCycle), .instr_count_o(bInstr), .reg_write_count_o(bRw),
        .mem_write_count_o(bMw), .stop_o(bStop), .stop_cause_o(bCause),
        .trace_rd_idx_i(rdIdx), .trace_rd_pc_o(bTracePc), .trace_count_o(bTraceCnt));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nPass = 0;
    int nTotal = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Behavioural reference for instance A.
    int          mCycle, mInstr, mRw, mMw, mCause, mRun;
    bit          mStop, mHasPrev;
    logic [31:0] mPrevPc, mRdPc;
    logic [4:0]  mPrevSt;
    logic [31:0] hist[$];

    function automatic int satAdd(input int v, input bit en);
        return (en && v < A_MAX) ? v + 1 : v;
    endfunction

    function automatic logic [31:0] histAt(input int idx);
        if (idx < hist.size() && idx < DEPTH) return hist[hist.size() - 1 - idx];
        return 32'd0;
    endfunction

    task automatic modelReset();
        mCycle = 0; mInstr = 0; mRw = 0; mMw = 0; mCause = 0; mRun = 0;
        mStop = 0; mHasPrev = 0; mPrevPc = 0; mPrevSt = 0; mRdPc = 0;
        hist.delete();
    endtask

    task automatic modelStep();
        mRdPc = histAt(int'(rdIdx));
        if (mStop) return;
        mCycle = satAdd(mCycle, 1'b1);
        mInstr = satAdd(mInstr, irW);
        mRw    = satAdd(mRw, regW);
        mMw    = satAdd(mMw, memW);
        mRun   = (mHasPrev && pc == mPrevPc && estado == mPrevSt) ? mRun + 1 : 0;
        mHasPrev = 1; mPrevPc = pc; mPrevSt = estado;
        if (exc) begin mStop = 1; mCause = 3; end
        else if (mRun == HANG) begin mStop = 1; mCause = 2; end
        else if (mCycle == TIMEOUT) begin mStop = 1; mCause = 1; end
        if (irW) hist.push_back(pc);
    endtask

    task automatic checkModel();
        int expCnt;
        expCnt = (hist.size() < DEPTH) ? hist.size() : DEPTH;
        check("rnd_cycle", 64'(aCycle), 64'(mCycle));
        check("rnd_instr", 64'(aInstr), 64'(mInstr));
        check("rnd_regw",  64'(aRw),    64'(mRw));
        check("rnd_memw",  64'(aMw),    64'(mMw));
        check("rnd_stop",  64'(aStop),  64'(mStop));
        check("rnd_cause", 64'(aCause), 64'(mCause));
        check("rnd_trpc",  64'(aTracePc),  TRACE_ON ? 64'(mRdPc) : 64'd0);
        check("rnd_trcnt", 64'(aTraceCnt), TRACE_ON ? 64'(expCnt) : 64'd0);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1; pc = 0; estado = 0; irW = 0; regW = 0; memW = 0; exc = 0; rdIdx = 0;
        @(posedge clock);
        #1;
        reset = 0;
        modelReset();
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  st;
        bit          ir, rw, mw, ex;
        int          eCycle, eInstr, eRw, eMw;
        bit          eStop;
        int          eCause;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h100, 5'd1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[1] = '{32'h104, 5'd2, 0, 1, 0, 0, 2, 1, 1, 0, 0, 0};
        vecs[2] = '{32'h108, 5'd3, 1, 1, 1, 0, 3, 2, 2, 1, 0, 0};
        vecs[3] = '{32'h10C, 5'd4, 0, 0, 1, 0, 4, 2, 2, 2, 0, 0};
        vecs[4] = '{32'h110, 5'd5, 1, 0, 0, 1, 5, 3, 2, 2, 1, 3};
        vecs[5] = '{32'h114, 5'd6, 1, 1, 1, 0, 5, 3, 2, 2, 1, 3};

        // Reset state of both instances.
        doReset();
        check("rst_a_cycle", 64'(aCycle), 64'd0);
        check("rst_a_stop",  64'(aStop),  64'd0);
        check("rst_a_cause", 64'(aCause), 64'd0);
        check("rst_a_trpc",  64'(aTracePc), 64'd0);
        check("rst_a_trcnt", 64'(aTraceCnt), 64'd0);
        check("rst_b_cycle", 64'(bCycle), 64'd0);

        // Table: counters, exception stop and freeze.
        for (int i = 0; i < 6; i++) begin
            pc = vecs[i].pc; estado = vecs[i].st; irW = vecs[i].ir;
            regW = vecs[i].rw; memW = vecs[i].mw; exc = vecs[i].ex;
            tick();
            check("tbl_cycle", 64'(aCycle), 64'(vecs[i].eCycle));
            check("tbl_instr", 64'(aInstr), 64'(vecs[i].eInstr));
            check("tbl_regw",  64'(aRw),    64'(vecs[i].eRw));
            check("tbl_memw",  64'(aMw),    64'(vecs[i].eMw));
            check("tbl_stop",  64'(aStop),  64'(vecs[i].eStop));
            check("tbl_cause", 64'(aCause), 64'(vecs[i].eCause));
        end

        // Timeout with a moving PC.
        doReset();
        for (int n = 1; n <= TIMEOUT; n++) begin
            pc = 32'(4 * n); estado = 5'd1;
            tick();
            if (n == TIMEOUT - 1) check("to_not_yet", 64'(aStop), 64'd0);
        end
        check("to_stop",  64'(aStop),  64'd1);
        check("to_cause", 64'(aCause), 64'd1);
        check("to_cycle", 64'(aCycle), 64'd100);
        for (int n = 0; n < 10; n++) begin pc = 32'(8000 + 4 * n); tick(); end
        check("to_frozen", 64'(aCycle), 64'd100);

        // Hang with constant PC/state from reset release.
        doReset();
        pc = 32'h40; estado = 5'd3;
        for (int n = 1; n <= HANG + 1; n++) begin
            tick();
            if (n == HANG) check("hang_not_yet", 64'(aStop), 64'd0);
        end
        check("hang_stop",  64'(aStop),  64'd1);
        check("hang_cause", 64'(aCause), 64'd2);
        check("hang_cycle", 64'(aCycle), 64'd9);

        // Hang restarted by one PC change (sixth sample differs).
        doReset();
        estado = 5'd3;
        for (int n = 1; n <= 14; n++) begin
            pc = (n < 6) ? 32'h40 : 32'h44;
            tick();
            if (n == 13) check("hangr_not_yet", 64'(aStop), 64'd0);
        end
        check("hangr_stop",  64'(aStop),  64'd1);
        check("hangr_cause", 64'(aCause), 64'd2);

        // Exception, hang and timeout in the same cycle, then hang and timeout together.
        for (int withExc = 1; withExc >= 0; withExc--) begin
            doReset();
            estado = 5'd2;
            for (int n = 1; n <= TIMEOUT; n++) begin
                pc  = (n <= 92) ? 32'(4 * n) : 32'(4 * 92);
                exc = (withExc == 1) && (n == TIMEOUT);
                tick();
                if (n == TIMEOUT - 1) check("co_not_yet", 64'(aStop), 64'd0);
            end
            exc = 0;
            check("co_stop",  64'(aStop),  64'd1);
            check("co_cause", 64'(aCause), (withExc == 1) ? 64'd3 : 64'd2);
        end

        // Reset while STOPPED.
        reset = 1;
        @(posedge clock);
        #1;
        check("rs_cycle", 64'(aCycle), 64'd0);
        check("rs_stop",  64'(aStop),  64'd0);
        check("rs_cause", 64'(aCause), 64'd0);
        reset = 0;
        modelReset();
        pc = 32'h200;
        tick();
        check("rs_resume", 64'(aCycle), 64'd1);

        // Trace: 20 pushes into a 16-entry buffer.
        doReset();
        irW = 1;
        for (int n = 0; n < 20; n++) begin pc = 32'(4 * n); estado = 5'(n); tick(); end
        irW = 0; pc = 32'h1000;
        check("tr_count", 64'(aTraceCnt), TRACE_ON ? 64'd16 : 64'd0);
        rdIdx = 0; tick();
        check("tr_idx0", 64'(aTracePc), TRACE_ON ? 64'h4C : 64'd0);
        rdIdx = 15; tick();
        check("tr_idx15", 64'(aTracePc), TRACE_ON ? 64'h10 : 64'd0);
        rdIdx = 1; #1;
        check("tr_latency_hold", 64'(aTracePc), TRACE_ON ? 64'h10 : 64'd0);
        tick();
        check("tr_idx1", 64'(aTracePc), TRACE_ON ? 64'h48 : 64'd0);
        rdIdx = 0; irW = 1; pc = 32'h50; tick();
        check("tr_push_read", 64'(aTracePc), TRACE_ON ? 64'h4C : 64'd0);
        irW = 0; pc = 32'h1004; tick();
        check("tr_new_head", 64'(aTracePc), TRACE_ON ? 64'h50 : 64'd0);

        // Narrow counters saturate.
        doReset();
        regW = 1;
        for (int n = 1; n <= 20; n++) begin pc = 32'(4 * n); tick(); end
        regW = 0;
        check("sat_regw",  64'(bRw),    64'd15);
        check("sat_cycle", 64'(bCycle), 64'd15);
        check("sat_instr", 64'(bInstr), 64'd0);
        check("sat_memw",  64'(bMw),    64'd0);
        check("sat_stop",  64'(bStop),  64'd0);

        // Randomized traffic against the model.
        for (int run = 0; run < 6; run++) begin
            int keepPct;
            keepPct = 20 + run * 15;
            doReset();
            for (int n = 0; n < 130; n++) begin
                if ($urandom_range(0, 99) >= keepPct) pc = 32'($urandom_range(0, 255)) << 2;
                if ($urandom_range(0, 9) == 0) estado = 5'($urandom_range(0, 31));
                irW   = 1'($urandom_range(0, 1));
                regW  = 1'($urandom_range(0, 1));
                memW  = 1'($urandom_range(0, 1));
                exc   = ($urandom_range(0, 149) == 0);
                rdIdx = 4'($urandom_range(0, 15));
                tick();
                checkModel();
            end
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end
endmodule
